// File: rtl/prog_loader_if.sv
// Byte-stream, instruction-memory write and core-control signals of prog_loader.
// master drives the stream and start; slave is the loader itself.
interface prog_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Streams a little-endian program image (16-bit word count header, then words) into
// instruction memory while holding the core in reset. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module prog_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd6;
`else
  // one-cycle hold so core_rst drops only after the final write pulse
  localparam logic [2:0] S_FIN  = 3'd6;
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]       chk_q;
`endif

  logic        xfer;
  logic [15:0] hdr;
  logic        last_word;
  logic        rdy;

  assign hdr       = {bus.in_data, cnt[7:0]};
  assign last_word = (word_idx == cnt - CNT_W'(1));

  always_comb begin
    rdy = 1'b0;
    case (state)
      S_LEN0, S_LEN1, S_DATA: rdy = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:                  rdy = 1'b1;
`endif
      default:                rdy = 1'b0;
    endcase
  end

  assign xfer           = bus.in_valid && rdy;
  assign bus.in_ready   = rdy;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = (state != S_DONE);
  assign bus.done       = (state == S_DONE);
  assign bus.error      = (state == S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            state    <= S_LEN0;
            byte_idx <= '0;
            word_idx <= '0;
          end
        end
        S_LEN0: begin
          if (xfer) begin
            cnt   <= CNT_W'(bus.in_data);
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q <= bus.in_data;
`endif
            state <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (xfer) begin
            cnt <= CNT_W'(hdr);
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q <= chk_q ^ bus.in_data;
`endif
            if (hdr == 16'd0)
`ifdef PROG_LOADER_CHECKSUM_EN
              state <= S_CHK;
`else
              state <= S_DONE;
`endif
            else if (32'(hdr) > DEPTH)
              state <= S_ERR;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q <= chk_q ^ bus.in_data;
`endif
            case (byte_idx)
              2'd0: asm_q[7:0]   <= bus.in_data;
              2'd1: asm_q[15:8]  <= bus.in_data;
              2'd2: asm_q[23:16] <= bus.in_data;
              default: begin
                we_q     <= 1'b1;
                addr_q   <= 32'(word_idx) << 2;
                wdata_q  <= {bus.in_data, asm_q};
                word_idx <= word_idx + CNT_W'(1);
                if (last_word)
`ifdef PROG_LOADER_CHECKSUM_EN
                  state <= S_CHK;
`else
                  state <= S_FIN;
`endif
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) state <= (chk_q == bus.in_data) ? S_DONE : S_ERR;
        end
`else
        S_FIN: state <= S_DONE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven image loads plus hand-written
// stall, reset, depth-boundary and checksum sequences; writes checked through a scoreboard.
module tb_prog_loader;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if bus();
  prog_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] b[12];
    int         n;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t       vt[4];
  wr_t        sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] run_xor;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_BUILD = 1'b1;
`else
  localparam bit CHK_BUILD = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // write monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!rst && bus.imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", bus.imem_addr, e.addr);
        chk("wr_data", bus.imem_wdata, e.data);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    run_xor = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin @(negedge clk); bus.in_valid = 1'b0; end
    @(negedge clk); bus.in_valid = 1'b1; bus.in_data = b;
    while (bus.in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (bus.in_ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready_timeout: got %b want 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    run_xor = run_xor ^ b;
    @(posedge clk); #1; bus.in_valid = 1'b0;
  endtask

  task automatic finish_check(input int nwords, input logic exp_done, input logic exp_err);
    int lat;
    lat = (nwords > 0 && !CHK_BUILD && !exp_err) ? 2 : 1;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk("core_rst_hold", {31'd0, bus.core_rst}, 32'd1);
    end
    @(negedge clk);
    chk("done",     {31'd0, bus.done},     {31'd0, exp_done});
    chk("error",    {31'd0, bus.error},    {31'd0, exp_err});
    chk("core_rst", {31'd0, bus.core_rst}, {31'd0, ~exp_done});
    chk("in_ready_end", {31'd0, bus.in_ready}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    if (exp_done && nwords > 0) chk("addr_hold", bus.imem_addr, (nwords - 1) * 4);
  endtask

  task automatic run_vec(input vec_t v, input int maxgap);
    int cnt;
    cnt = {16'd0, v.b[1], v.b[0]};
    if (cnt <= DEPTH)
      for (int k = 0; k < cnt; k++)
        sb.push_back({32'(k * 4), v.b[2+4*k+3], v.b[2+4*k+2], v.b[2+4*k+1], v.b[2+4*k]});
    pulse_start();
    for (int i = 0; i < v.n; i++) send_byte(v.b[i], maxgap > 0 ? $urandom_range(0, maxgap) : 0);
    if (CHK_BUILD && !v.exp_err) send_byte(run_xor, 0);
    finish_check(cnt <= DEPTH ? cnt : 0, v.exp_done, v.exp_err);
  endtask

  // random image; pushes each word as its last byte is sent
  task automatic send_image(input int cnt, input int ndata, input int maxgap);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    pulse_start();
    send_byte(cnt[7:0], 0);
    send_byte(cnt[15:8], 0);
    for (int i = 0; i < ndata; i++) begin
      b = 8'($urandom);
      w = {b, w[31:8]};
      if (i % 4 == 3) sb.push_back({32'((i / 4) * 4), w});
      send_byte(b, maxgap > 0 ? $urandom_range(0, maxgap) : 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{b: '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h00, 8'h00},
              n: 10, exp_done: 1'b1, exp_err: 1'b0};
    vt[1] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              n: 2, exp_done: 1'b1, exp_err: 1'b0};
    vt[2] = '{b: '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              n: 6, exp_done: 1'b1, exp_err: 1'b0};
    vt[3] = '{b: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              n: 2, exp_done: 1'b0, exp_err: 1'b1};

    rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; run_xor = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("rst_imem_we",   {31'd0, bus.imem_we},  32'd0);
    chk("rst_imem_addr", bus.imem_addr,         32'd0);
    chk("rst_imem_wdata", bus.imem_wdata,       32'd0);
    chk("rst_core_rst",  {31'd0, bus.core_rst}, 32'd1);
    chk("rst_done",      {31'd0, bus.done},     32'd0);
    chk("rst_error",     {31'd0, bus.error},    32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // basic, empty, reload after DONE, oversize
    for (int i = 0; i < 4; i++) run_vec(vt[i], 0);

    // stalls inside words, with an ignored start mid-load
    sb.push_back({32'd0, 32'h00500513});
    sb.push_back({32'd4, 32'h00A00593});
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(vt[0].b[i], $urandom_range(0, 4));
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("start_ignored_rdy", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 5; i < 10; i++) send_byte(vt[0].b[i], $urandom_range(0, 4));
    if (CHK_BUILD) send_byte(run_xor, 0);
    finish_check(2, 1'b1, 1'b0);

    // reset during the third word
    send_image(3, 10, 3);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("mid_rst_core_rst", {31'd0, bus.core_rst}, 32'd1);
    chk("mid_rst_done",     {31'd0, bus.done},     32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_core_rst2", {31'd0, bus.core_rst}, 32'd1);
    chk("mid_rst_sb_empty", sb.size(), 32'd0);

    // count == DEPTH
    send_image(DEPTH, DEPTH * 4, 0);
    if (CHK_BUILD) send_byte(run_xor, 0);
    finish_check(DEPTH, 1'b1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    sb.push_back({32'd0, 32'h44332211});
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h45, 0);
    finish_check(1, 1'b1, 1'b0);

    sb.push_back({32'd0, 32'h44332211});
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h00, 0);
    finish_check(1, 1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
